div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle 16-bit integer divider sequencer for the execute stage. It accepts one divide request through a start/busy/done handshake and runs 16 restoring-division iterations. Every subtraction is formed as A + ~B + 1, with ~B produced by the existing 16-bit conditional inverter. It handles unsigned and two's-complement signed operands and flags divide-by-zero. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, 16: operand width; only 16 is supported.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `signed_op`  in  1  1 = signed division, 0 = unsigned; sampled with `start`.
- `dividend`  in  16  numerator; sampled with `start`.
- `divisor`  in  16  denominator; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient`  out  16  registered result.
- `remainder`  out  16  registered result.
- `div_zero`  out  1  registered; set with `done` when divisor == 0.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE → PREP on `start`. Operands and `signed_op` are latched, `busy` rises next cycle. `start` is ignored in every other state.
- PREP, signed mode: record the dividend and divisor sign bits, then replace each negative operand by its magnitude (inverter with Op=1, then +1).
  - 0x8000 maps to magnitude 0x8000, treated as unsigned.
  - Clear the 17-bit partial remainder and the 4-bit iteration counter.
- PREP with divisor == 0 → DONE directly. Results: `quotient`=0xFFFF, `remainder`=original `dividend`, `div_zero`=1.
- ITER, one step per cycle, 16 steps:
  - Shift {remainder, dividend} left by one.
  - Compute trial = rem[16:0] + {1'b1, ~divisor} + 1 in 17 bits.
  - If trial bit 16 == 0, rem := trial and the quotient LSB := 1.
  - Otherwise rem is unchanged and the quotient LSB := 0.
  - The counter increments each step. After the step where counter == 15 the counter wraps to 0 and the FSM goes to FIX.
- FIX, signed mode only:
  - Negate the quotient if the two sign bits differ.
  - Negate the remainder if the dividend was negative. The remainder sign always follows the dividend.
  - In unsigned mode FIX passes the values through unchanged.
- DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `quotient`, `remainder` and `div_zero` hold their values until the next accepted `start`. `div_zero` clears at that point.
- Overflow case -32768 / -1 yields `quotient`=0x8000, `remainder`=0, `div_zero`=0. This is two's-complement wrap; no flag is raised.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, counter=0.
- `rst` overrides everything, including mid-operation. The operation in flight is abandoned, no `done` is produced, and outputs return to their reset values on the next edge.
- Cycle numbering: N is the edge where `start` is sampled in IDLE.
  - PREP occupies cycle N+1.
  - ITER occupies N+2 through N+17.
  - FIX occupies N+18.
  - `done` is high during cycle N+19.
  - Normal latency is 19 cycles.
- Divide-by-zero: `done` is high during cycle N+2.
- `busy` is high from N+1 through the `done` cycle inclusive. It is low in IDLE.
- Back-to-back operation: a `start` asserted in the cycle after `done` (FSM in IDLE) is accepted. A `start` asserted in the same cycle as `done` is ignored.
- Inputs other than `start` may change freely after the accept edge.

## Structure
- Shared header: localparams for state encoding (3 bits), `WIDTH`=16, `ITERS`=16, and the divide-by-zero quotient constant 0xFFFF.
- One sub-module instance: `inverse` for the ~divisor term in ITER, with Op tied to 1.
- Conditional negation in PREP and FIX reuses the same complement-plus-one logic through a local function.
- A single FSM block, a datapath register block, and a counter. No other sub-modules.

## Test plan
- Unsigned 100 / 7, start at cycle N → `done` at N+19, `quotient`=14, `remainder`=2, `div_zero`=0, `busy` high N+1..N+19.
- Signed 0xFF9C (-100) / 7 → `quotient`=0xFFF2 (-14), `remainder`=0xFFFE (-2). Signed 100 / 0xFFF9 (-7) → `quotient`=0xFFF2, `remainder`=2.
- Unsigned 0x1234 / 0 → `done` at N+2, `quotient`=0xFFFF, `remainder`=0x1234, `div_zero`=1. A following 9 / 3 → `quotient`=3, `remainder`=0, `div_zero`=0.
- Signed 0x8000 / 0xFFFF → `quotient`=0x8000, `remainder`=0. Unsigned 0xFFFF / 1 → `quotient`=0xFFFF, `remainder`=0.
- Start 50 / 5, then pulse `start` with 9 / 2 at N+5 and again in the `done` cycle → both ignored; results are 10 / 0. A `start` in the cycle after `done` is accepted.
- Assert `rst` at N+10 mid-ITER → next cycle: IDLE, all outputs 0, no `done` pulse. A new 7 / 2 completes normally with `quotient`=3, `remainder`=1.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared constants and state encoding for the sequential 16-bit divider.
package div_seq_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int ITERS     = 16;
  localparam int CNT_W     = 4;
  localparam logic [DIV_WIDTH-1:0] DZ_QUOT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;
endpackage

// File: rtl/div_seq_inverse.sv
// Conditional bitwise inverter: passes the operand through or returns its one's complement.
module div_seq_inverse #(
  parameter int WIDTH = 16
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = op_i ? ~a_i : a_i;
endmodule

// File: rtl/div_seq.sv
// Start/busy/done restoring divider: one quotient bit per cycle, signed operands handled
// by dividing magnitudes and fixing the result signs afterwards.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_e           state_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] quot_q, rmd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q, sa_q, sb_q;
  logic [WIDTH-1:0] a_q, b_q, dvd_q, dvs_q;
  logic [WIDTH:0]   prem_q;

  logic [WIDTH-1:0] dvs_inv;
  logic [WIDTH:0]   prem_sh, trial, prem_d;
  logic [WIDTH-1:0] dvd_d;
  logic             qbit, last_iter, b_zero;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + WIDTH'(1)) : x;
  endfunction

  div_seq_inverse #(.WIDTH(WIDTH)) inverse (
    .op_i (1'b1),
    .a_i  (dvs_q),
    .y_o  (dvs_inv)
  );

  // The partial remainder never exceeds 16 bits between steps, so the shifted top bit is always 0.
  always_comb begin
    prem_sh   = (prem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    trial     = prem_sh + {1'b1, dvs_inv} + (WIDTH+1)'(1);
    qbit      = ~trial[WIDTH];
    prem_d    = qbit ? trial : prem_sh;
    dvd_d     = {dvd_q[WIDTH-2:0], qbit};
    last_iter = (cnt_q == CNT_W'(ITERS-1));
    b_zero    = (b_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_PREP;
          busy_q  <= 1'b1;
        end
        S_PREP: if (b_zero) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_ITER;
        end
        S_ITER: if (last_iter) state_q <= S_FIX;
        S_FIX: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Working registers; sa_q/sb_q already fold in the signed-mode qualifier.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (start) begin
        sgn_q <= signed_op;
        a_q   <= dividend;
        b_q   <= divisor;
      end
      S_PREP: begin
        sa_q   <= sgn_q & a_q[WIDTH-1];
        sb_q   <= sgn_q & b_q[WIDTH-1];
        dvd_q  <= cneg(a_q, sgn_q & a_q[WIDTH-1]);
        dvs_q  <= cneg(b_q, sgn_q & b_q[WIDTH-1]);
        prem_q <= '0;
      end
      S_ITER: begin
        prem_q <= prem_d;
        dvd_q  <= dvd_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_PREP) begin
      cnt_q <= '0;
    end else if (state_q == S_ITER) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rmd_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) dz_q <= 1'b0;
        S_PREP: if (b_zero) begin
          quot_q <= DZ_QUOT;
          rmd_q  <= a_q;
          dz_q   <= 1'b1;
        end
        S_FIX: begin
          quot_q <= cneg(dvd_q, sa_q ^ sb_q);
          rmd_q  <= cneg(prem_q[WIDTH-1:0], sa_q);
        end
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus ignored-start and mid-operation reset sequences.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst, start, signed_op;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [15:0] quotient, remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  div_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the bench one step into the cycle after the accept edge (cycle N+1).
  task automatic pulse_start(input logic s, input logic [15:0] a, input logic [15:0] b);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    signed_op = ~s;
    dividend  = 16'($urandom);
    divisor   = 16'($urandom);
  endtask

  // Returns the cycle offset (relative to the current cycle = 1) at which done is seen, or -1.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = j;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edz, input int elat);
    int   lat;
    logic bok;
    pulse_start(s, a, b);
    wait_done(lat, bok);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy"}, 32'(bok), 32'(1));
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 32'({busy, done}), 32'(0));
  endtask

  initial begin
    int   lat;
    logic bok;
    logic seen;

    vecs[0]  = '{s:1'b0, a:16'd100,   b:16'd7,      q:16'd14,   r:16'd2,    dz:1'b0, lat:19};
    vecs[1]  = '{s:1'b1, a:16'hFF9C,  b:16'd7,      q:16'hFFF2, r:16'hFFFE, dz:1'b0, lat:19};
    vecs[2]  = '{s:1'b1, a:16'd100,   b:16'hFFF9,   q:16'hFFF2, r:16'd2,    dz:1'b0, lat:19};
    vecs[3]  = '{s:1'b0, a:16'h1234,  b:16'd0,      q:16'hFFFF, r:16'h1234, dz:1'b1, lat:2};
    vecs[4]  = '{s:1'b0, a:16'd9,     b:16'd3,      q:16'd3,    r:16'd0,    dz:1'b0, lat:19};
    vecs[5]  = '{s:1'b1, a:16'h8000,  b:16'hFFFF,   q:16'h8000, r:16'd0,    dz:1'b0, lat:19};
    vecs[6]  = '{s:1'b0, a:16'hFFFF,  b:16'd1,      q:16'hFFFF, r:16'd0,    dz:1'b0, lat:19};
    vecs[7]  = '{s:1'b1, a:16'hFFF9,  b:16'hFFFE,   q:16'd3,    r:16'hFFFF, dz:1'b0, lat:19};
    vecs[8]  = '{s:1'b1, a:16'hFF00,  b:16'd0,      q:16'hFFFF, r:16'hFF00, dz:1'b1, lat:2};
    vecs[9]  = '{s:1'b0, a:16'h8000,  b:16'h8000,   q:16'd1,    r:16'd0,    dz:1'b0, lat:19};
    vecs[10] = '{s:1'b1, a:16'h8000,  b:16'd2,      q:16'hC000, r:16'd0,    dz:1'b0, lat:19};
    vecs[11] = '{s:1'b0, a:16'd5,     b:16'd9,      q:16'd0,    r:16'd5,    dz:1'b0, lat:19};

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_quotient", 32'(quotient), 32'(0));
    check("reset_remainder", 32'(remainder), 32'(0));
    check("reset_div_zero", 32'(div_zero), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
    end

    // Starts during ITER and during the done cycle must both be ignored.
    pulse_start(1'b0, 16'd50, 16'd5);
    repeat (4) begin
      @(posedge clk); #1;
    end
    signed_op = 1'b0; dividend = 16'd9; divisor = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bok);
    check("ign_latency", 32'((lat > 0) ? lat + 5 : lat), 32'(19));
    check("ign_busy", 32'(bok), 32'(1));
    check("ign_quotient", 32'(quotient), 32'(10));
    check("ign_remainder", 32'(remainder), 32'(0));
    signed_op = 1'b0; dividend = 16'd9; divisor = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_done_cycle_busy", 32'({busy, done}), 32'(0));
    @(posedge clk); #1;
    check("ign_still_idle", 32'(busy), 32'(0));
    check("ign_hold_quotient", 32'(quotient), 32'(10));

    // Reset in the middle of ITER abandons the operation.
    run_op("pre_rst", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 19);
    pulse_start(1'b0, 16'd1000, 16'd3);
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("rst_busy_before", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_quotient", 32'(quotient), 32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_div_zero", 32'(div_zero), 32'(0));
    seen = 1'b0;
    repeat (25) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_no_done", 32'(seen), 32'(0));
    run_op("post_rst", 1'b0, 16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
